// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS multiply/divide unit with HI/LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  logic          busy_q;
  logic [CW-1:0] counter;
  logic [31:0]   shadow_hi, shadow_lo;
  logic          start_w, is_mult, is_sdiv;
  logic [63:0]   prod_s, prod_u, res;
  logic [31:0]   div_a, div_b, div_b_nz, quo, rem, quo_s, rem_s;
  assign is_mult = md_op_i == 3'd1 || md_op_i == 3'd2;
  assign is_sdiv = md_op_i == 3'd3;
  assign start_w = md_op_i >= 3'd1 && md_op_i <= 3'd4 && !busy_q;
  assign busy_o  = start_w | busy_q;
  // Result for the op being accepted; signed divide works on magnitudes so INT_MIN/-1 wraps cleanly
  always_comb begin
    prod_s   = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
    prod_u   = {32'b0, rs_i} * {32'b0, rt_i};
    div_a    = is_sdiv && rs_i[31] ? -rs_i : rs_i;
    div_b    = is_sdiv && rt_i[31] ? -rt_i : rt_i;
    div_b_nz = div_b == 32'b0 ? 32'd1 : div_b;
    quo      = div_a / div_b_nz;
    rem      = div_a % div_b_nz;
    quo_s    = is_sdiv && (rs_i[31] ^ rt_i[31]) ? -quo : quo;
    rem_s    = is_sdiv && rs_i[31] ? -rem : rem;
    res      = md_op_i == 3'd1 ? prod_s :
               md_op_i == 3'd2 ? prod_u :
               rt_i == 32'b0   ? {hi_o, lo_o} : {rem_s, quo_s};
  end
  // Start, count down and commit; HI/LO only change on commit or mthi/mtlo when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= 1'b0;
      counter   <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
      hi_o      <= '0;
      lo_o      <= '0;
    end else if (start_w) begin
      {shadow_hi, shadow_lo} <= res;
      counter <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      counter <= counter - 1'b1;
      if (counter == CW'(1)) begin
        hi_o   <= shadow_hi;
        lo_o   <= shadow_lo;
        busy_q <= 1'b0;
      end
    end else if (md_op_i == 3'd5) begin
      hi_o <= rs_i;
    end else if (md_op_i == 3'd6) begin
      lo_o <= rs_i;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized self-checking bench for md_unit against an arithmetic reference
module tb_md_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs = '0, rt = '0;
  logic        busy;
  logic [31:0] hi, lo;
  logic [31:0] m_hi = '0, m_lo = '0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op_i(md_op), .rs_i(rs), .rt_i(rt),
    .busy_o(busy), .hi_o(hi), .lo_o(lo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, b, h, l);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    longint q, r;
    case (op)
      3'd1: return 64'(sa * sb);
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 0) return {h, l};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 0) return {h, l};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return {h, l};
    endcase
  endfunction

  task automatic run_arith(input logic [2:0] op, input logic [31:0] a, b, output int cyc, output bit held);
    logic [31:0] oh = hi, ol = lo;
    md_op = op; rs = a; rt = b;
    #1;
    cyc = 0;
    held = 1;
    while (busy && cyc < 40) begin
      cyc++;
      if (hi !== oh || lo !== ol) held = 0;
      tick;
      md_op = 3'd0;
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1; md_op = 0;
    tick; tick;
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want 0", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want 0", lo); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 0;
    tick;
  endtask

  task automatic test_mult;
    int cyc; bit held;
    run_arith(3'd1, 32'd3, 32'hFFFFFFFE, cyc, held);
    tests++; if (cyc != 6) begin fails++; $display("FAIL mult_busy got %0d want 6", cyc); end
    tests++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) begin fails++; $display("FAIL mult_res got %h_%h want ffffffff_fffffffa", hi, lo); end
    run_arith(3'd2, 32'hFFFFFFFF, 32'd2, cyc, held);
    tests++; if (!held) begin fails++; $display("FAIL multu_hold got changed want held"); end
    tests++; if ({hi, lo} !== 64'h00000001_FFFFFFFE) begin fails++; $display("FAIL multu_res got %h_%h want 00000001_fffffffe", hi, lo); end
    m_hi = hi === 32'h1 ? 32'h1 : 32'h1; m_lo = 32'hFFFFFFFE;
  endtask

  task automatic test_div;
    int cyc; bit held;
    run_arith(3'd3, 32'hFFFFFFF9, 32'd2, cyc, held);
    tests++; if (cyc != 11 || !held) begin fails++; $display("FAIL div_busy got %0d held %0d want 11 held 1", cyc, held); end
    tests++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin fails++; $display("FAIL div_res got %h_%h want ffffffff_fffffffd", hi, lo); end
    run_arith(3'd4, 32'd7, 32'd2, cyc, held);
    tests++; if ({hi, lo} !== 64'h00000001_00000003) begin fails++; $display("FAIL divu_res got %h_%h want 00000001_00000003", hi, lo); end
    run_arith(3'd3, 32'h80000000, 32'hFFFFFFFF, cyc, held);
    tests++; if ({hi, lo} !== 64'h00000000_80000000) begin fails++; $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi, lo); end
    m_hi = 32'h0; m_lo = 32'h80000000;
  endtask

  task automatic test_move;
    int cyc; bit held;
    md_op = 3'd5; rs = 32'h12345678;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mthi_busy got %b want 0", busy); end
    tick;
    md_op = 3'd6; rs = 32'h9ABCDEF0;
    #1;
    tests++; if (hi !== 32'h12345678 || busy !== 1'b0) begin fails++; $display("FAIL mthi got %h busy %b want 12345678 busy 0", hi, busy); end
    tick;
    md_op = 3'd0;
    tests++; if (lo !== 32'h9ABCDEF0) begin fails++; $display("FAIL mtlo got %h want 9abcdef0", lo); end
    run_arith(3'd3, 32'd55, 32'd0, cyc, held);
    tests++; if (cyc != 11) begin fails++; $display("FAIL div0_busy got %0d want 11", cyc); end
    tests++; if ({hi, lo} !== 64'h12345678_9ABCDEF0) begin fails++; $display("FAIL div0_keep got %h_%h want 12345678_9abcdef0", hi, lo); end
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
  endtask

  task automatic test_ignore;
    logic [31:0] oh = hi, ol = lo;
    md_op = 3'd1; rs = 32'd7; rt = 32'd9;
    tick;
    md_op = 3'd0;
    tick;
    md_op = 3'd6; rs = 32'hDEAD;
    tick;
    md_op = 3'd2; rs = 32'hFFFFFFFF; rt = 32'hFFFFFFFF;
    tick;
    tests++; if (busy !== 1'b1 || hi !== oh || lo !== ol) begin fails++; $display("FAIL ign_mid got busy %b %h_%h want 1 %h_%h", busy, hi, lo, oh, ol); end
    tick;
    tests++; if (busy !== 1'b1 || hi !== oh || lo !== ol) begin fails++; $display("FAIL ign_last got busy %b %h_%h want 1 %h_%h", busy, hi, lo, oh, ol); end
    tick;
    md_op = 3'd0;
    #1;
    tests++; if (busy !== 1'b0 || {hi, lo} !== 64'd63) begin fails++; $display("FAIL ign_commit got busy %b %h_%h want 0 00000000_0000003f", busy, hi, lo); end
    tick;
    tests++; if (busy !== 1'b0 || {hi, lo} !== 64'd63) begin fails++; $display("FAIL ign_after got busy %b %h_%h want 0 00000000_0000003f", busy, hi, lo); end
    m_hi = 32'h0; m_lo = 32'd63;
  endtask

  task automatic test_random;
    int cyc; bit held;
    logic [2:0] op; logic [31:0] a, b; logic [63:0] exp;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(1, 6));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000001F;
      if (op == 3'd3 && $urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if (op <= 3'd4) begin
        exp = ref_md(op, a, b, m_hi, m_lo);
        run_arith(op, a, b, cyc, held);
        tests++; if (cyc != (op <= 3'd2 ? 6 : 11) || !held) begin fails++; $display("FAIL rnd_busy op %0d got %0d held %0d want %0d held 1", op, cyc, held, op <= 3'd2 ? 6 : 11); end
        tests++; if ({hi, lo} !== exp) begin fails++; $display("FAIL rnd_res op %0d a %h b %h got %h_%h want %h", op, a, b, hi, lo, exp); end
        {m_hi, m_lo} = exp;
      end else begin
        md_op = op; rs = a;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rnd_mv_busy got %b want 0", busy); end
        tick;
        md_op = 3'd0;
        if (op == 3'd5) m_hi = a; else m_lo = a;
        tests++; if (hi !== m_hi || lo !== m_lo) begin fails++; $display("FAIL rnd_mv got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
      end
    end
  endtask

  task automatic test_reset_abort;
    bit ok = 1;
    md_op = 3'd5; rs = 32'hA5A5A5A5;
    tick;
    md_op = 3'd6; rs = 32'h5A5A5A5A;
    tick;
    md_op = 3'd3; rs = 32'd100; rt = 32'd7;
    tick;
    md_op = 3'd0;
    tick; tick; tick;
    reset = 1;
    tick;
    tests++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin fails++; $display("FAIL abort got busy %b %h_%h want 0 0_0", busy, hi, lo); end
    reset = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) ok = 0;
    end
    tests++; if (!ok) begin fails++; $display("FAIL abort_nocommit got late commit want none, now %h_%h", hi, lo); end
    m_hi = 32'h0; m_lo = 32'h0;
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_move;
    test_ignore;
    test_random;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
